// File: rtl/axi_stream_pkg.sv
// Shared constants and state encoding for the AXI-Stream writer.
//   DEFAULT_TDATA_WIDTH : default stream data width in bits
//   DEFAULT_FIFO_DEPTH  : default internal buffer depth in words
//   state_e             : writer state (IDLE while start=0, RUN while start=1)
package axi_stream_pkg;

  localparam int unsigned DEFAULT_TDATA_WIDTH = 32;
  localparam int unsigned DEFAULT_FIFO_DEPTH  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous single-clock FIFO with occupancy count.
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   push, din : write request and data; ignored when full, even if popping
//   pop, dout : read request and oldest entry; pop ignored when empty
//   full, empty, count : occupancy status, count is log2(DEPTH)+1 bits
module sync_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/axi_stream_writer.sv
// Buffers upstream words (with their last flag) and emits them as an
// AXI4-Stream master.
//   M_AXIS_ACLK                 : clock
//   M_AXIS_ARESETN              : synchronous reset, active HIGH despite the name
//   start                       : level enable for accepting upstream data
//   data, data_valid, data_last : upstream word, valid, end-of-packet
//   ready                       : upstream word is accepted this cycle
//   M_AXIS_T*                   : AXI4-Stream master channel
module axi_stream_writer
  import axi_stream_pkg::*;
#(
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = DEFAULT_TDATA_WIDTH,
  parameter int unsigned C_FIFO_DEPTH         = DEFAULT_FIFO_DEPTH
) (
  input  logic                              M_AXIS_ACLK,
  input  logic                              M_AXIS_ARESETN,
  input  logic                              start,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   data,
  input  logic                              data_valid,
  input  logic                              data_last,
  output logic                              ready,
  output logic                              M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY
);

  localparam int unsigned CW = $clog2(C_FIFO_DEPTH) + 1;

  state_e                          state_q, state_d;
  logic [C_M_AXIS_TDATA_WIDTH:0]   fifo_dout;
  logic                            fifo_full, fifo_empty;
  logic [CW-1:0]                   fifo_count;
  logic                            push, pop;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)  state_d = RUN;
      RUN:     if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESETN) state_q <= IDLE;
    else                state_q <= state_d;
  end

  // Decoding from state_d lets a change on start affect ready in the same
  // cycle; reset masks ready so nothing is accepted while being cleared.
  assign ready = (state_d == RUN) && !fifo_full && !M_AXIS_ARESETN;
  assign push  = data_valid && ready;
  assign pop   = M_AXIS_TVALID && M_AXIS_TREADY;

  sync_fifo #(
    .WIDTH(C_M_AXIS_TDATA_WIDTH + 1),
    .DEPTH(C_FIFO_DEPTH)
  ) u_fifo (
    .clk   (M_AXIS_ACLK),
    .rst   (M_AXIS_ARESETN),
    .push  (push),
    .din   ({data_last, data}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Data and last are forced to zero when empty so stale memory never shows.
  assign M_AXIS_TVALID = (fifo_count != '0);
  assign M_AXIS_TDATA  = fifo_empty ? '0   : fifo_dout[C_M_AXIS_TDATA_WIDTH-1:0];
  assign M_AXIS_TLAST  = fifo_empty ? 1'b0 : fifo_dout[C_M_AXIS_TDATA_WIDTH];
  assign M_AXIS_TSTRB  = M_AXIS_TVALID ? '1 : '0;

endmodule

// File: tb/tb_axi_stream_writer.sv
module tb_axi_stream_writer;

  localparam int W = 32;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst, start, dv, dl, tready;
  logic [W-1:0] data;
  logic         ready, tvalid, tlast;
  logic [W-1:0] tdata;
  logic [3:0]   tstrb;

  always #5 clk = ~clk;

  axi_stream_writer #(
    .C_M_AXIS_TDATA_WIDTH(W),
    .C_FIFO_DEPTH(D)
  ) dut (
    .M_AXIS_ACLK    (clk),
    .M_AXIS_ARESETN (rst),
    .start          (start),
    .data           (data),
    .data_valid     (dv),
    .data_last      (dl),
    .ready          (ready),
    .M_AXIS_TVALID  (tvalid),
    .M_AXIS_TDATA   (tdata),
    .M_AXIS_TSTRB   (tstrb),
    .M_AXIS_TLAST   (tlast),
    .M_AXIS_TREADY  (tready)
  );

  // Reference: an ordered queue of {last, data} words held by the block.
  logic [W:0] q[$];
  int n_assert = 0;
  int n_fail   = 0;
  logic pushed;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at negedge, then advance the model at posedge.
  task automatic step();
    logic       exp_ready, exp_valid, do_pop;
    logic [W:0] f;
    @(negedge clk);
    exp_valid = (q.size() > 0);
    exp_ready = start && !rst && (q.size() < D);
    f = exp_valid ? q[0] : '0;
    chk("ready",  {31'b0, ready},  {31'b0, exp_ready});
    chk("tvalid", {31'b0, tvalid}, {31'b0, exp_valid});
    chk("tdata",  tdata,           f[W-1:0]);
    chk("tlast",  {31'b0, tlast},  {31'b0, f[W]});
    chk("tstrb",  {28'b0, tstrb},  exp_valid ? 32'hF : 32'h0);
    pushed = dv && exp_ready;
    do_pop = exp_valid && tready;
    @(posedge clk);
    if (rst) begin
      q.delete();
      pushed = 1'b0;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (pushed) q.push_back({dl, data});
    end
    #1;
  endtask

  // Present a word and hold it until the model says it was accepted.
  task automatic send(input logic [W-1:0] w, input logic last);
    data = w;
    dl   = last;
    dv   = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (pushed) return;
    end
    n_assert++;
    n_fail++;
    $error("FAIL send_timeout: word %h not accepted within 20 cycles", w);
  endtask

  task automatic idle_steps(input int n);
    dv = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dv = 1'b0; dl = 1'b0; tready = 1'b0; data = '0;
    @(posedge clk); #1;

    // Reset held, then idle with start low.
    for (int i = 0; i < 3; i++) step();
    rst = 1'b0;
    idle_steps(2);

    // Back-to-back streaming with TREADY high.
    start = 1'b1; tready = 1'b1;
    send(32'h11, 1'b0);
    send(32'h22, 1'b0);
    send(32'h33, 1'b0);
    send(32'h44, 1'b1);
    idle_steps(3);

    // Backpressure: fill, stall at 0xA4, then release.
    tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) tready = 1'b1;
      if (i < 4) send(32'hA0 + i, 1'b0);
      else begin
        data = 32'hA0 + i; dl = (i == 5); dv = 1'b1;
        for (int k = 0; k < 3; k++) step();
        tready = 1'b1;
        send(32'hA0 + i, i == 5);
      end
    end
    idle_steps(6);

    // Full with simultaneous pop: no push that cycle, accepted the next.
    tready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'hB0 + i, i == 3);
    tready = 1'b1;
    send(32'hB4, 1'b1);
    idle_steps(6);

    // Drop start mid-stream; buffered words still drain.
    tready = 1'b0;
    for (int i = 0; i < 3; i++) send(32'hC0 + i, i == 2);
    dv = 1'b1; data = 32'hCF; start = 1'b0;
    step();
    step();
    tready = 1'b1;
    idle_steps(4);

    // Reset mid-packet discards buffered words.
    start = 1'b1; tready = 1'b0;
    send(32'hD0, 1'b0);
    send(32'hD1, 1'b0);
    dv = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; tready = 1'b1;
    idle_steps(3);

    // Randomized traffic including occasional resets and stops.
    for (int i = 0; i < 400; i++) begin
      start  = ($urandom_range(0, 7) != 0);
      rst    = ($urandom_range(0, 63) == 0);
      dv     = $urandom_range(0, 1);
      dl     = $urandom_range(0, 1);
      data   = $urandom;
      tready = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 1'b0; start = 1'b0; tready = 1'b1;
    idle_steps(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_stream_writer.md
AXI_STREAM_WRITER -- requirements
Module: axi_stream_writer

Interface
REQ-001 The block SHALL have parameter C_M_AXIS_TDATA_WIDTH, default 32, giving the stream data width in bits (multiple of 8).
REQ-002 The block SHALL have parameter C_FIFO_DEPTH, default 4, giving the internal buffer depth in words (power of 2, at least 2).
REQ-003 M_AXIS_ACLK  in  1  sole clock; all logic is on its rising edge.
REQ-004 M_AXIS_ARESETN  in  1  synchronous, active-high reset (asserted = 1); the codebase port name is retained.
REQ-005 start  in  1  level enable; accept upstream data only while high.
REQ-006 data  in  C_M_AXIS_TDATA_WIDTH  upstream word.
REQ-007 data_valid  in  1  upstream word valid.
REQ-008 data_last  in  1  upstream word ends its packet.
REQ-009 ready  out  1  block accepts data this cycle.
REQ-010 M_AXIS_TVALID  out  1  stream valid.
REQ-011 M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH  stream data.
REQ-012 M_AXIS_TSTRB  out  C_M_AXIS_TDATA_WIDTH/8  byte strobes.
REQ-013 M_AXIS_TLAST  out  1  packet end.
REQ-014 M_AXIS_TREADY  in  1  downstream accepts.

Function
REQ-015 A push SHALL occur on a cycle where data_valid=1 and ready=1; data and data_last are stored together as one FIFO entry.
REQ-016 ready SHALL be combinational: start=1 AND entry count < C_FIFO_DEPTH; it SHALL NOT depend on M_AXIS_TREADY.
REQ-017 A push at full SHALL NOT occur, even when a pop happens in the same cycle.
REQ-018 M_AXIS_TVALID SHALL be 1 exactly when count > 0; TDATA and TLAST SHALL present the oldest entry.
REQ-019 A pop SHALL occur on a cycle where M_AXIS_TVALID=1 and M_AXIS_TREADY=1.
REQ-020 A word pushed in cycle N SHALL be visible on the stream no earlier than cycle N+1, and at N+1 when the FIFO was empty before the push.
REQ-021 A simultaneous push and pop SHALL leave count unchanged and SHALL preserve word order.
REQ-022 Read and write pointers SHALL wrap modulo C_FIFO_DEPTH. Count SHALL be log2(C_FIFO_DEPTH)+1 bits wide and SHALL never exceed C_FIFO_DEPTH or underflow.
REQ-023 M_AXIS_TSTRB SHALL be all ones whenever M_AXIS_TVALID=1, and 0 otherwise.
REQ-024 States: IDLE (start=0) and RUN (start=1). IDLE->RUN on start=1; RUN->IDLE on start=0. The transition takes effect in the same cycle that start changes.
REQ-025 In IDLE, ready SHALL be 0, while stored entries SHALL keep draining to the stream.
REQ-026 The block SHALL NOT insert, drop, or reorder words. TLAST SHALL be passed through unchanged, with no packet-length checking.
REQ-027 While TVALID=1 and TREADY=0, TDATA and TLAST SHALL remain stable.

Reset
REQ-028 While M_AXIS_ARESETN=1 at a clock edge, the block SHALL empty the FIFO and clear the pointers and count to 0. The state SHALL be IDLE.
REQ-029 During and directly after reset: ready=0, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, M_AXIS_TSTRB=0.
REQ-030 A reset asserted mid-packet SHALL discard all buffered words, and no partial packet SHALL be emitted afterwards.

Structure
REQ-031 A shared package axi_stream_pkg SHALL hold the default data width (32) and default FIFO depth (4) constants. It SHALL also hold the state encoding, IDLE=0 and RUN=1.
REQ-032 Buffering SHALL be one sub-module, sync_fifo: a parameterized width/depth FIFO with push, pop, full, empty and count.
REQ-033 Top-level logic SHALL be limited to the state register, the ready/strobe decode and port mapping.

Verification
REQ-034 Reset then idle: hold reset 3 cycles, start=0 -> ready=0, TVALID=0, TDATA=0, TSTRB=0 on every cycle.
REQ-035 Streaming: start=1, TREADY=1; push 0x11,0x22,0x33,0x44 with last on 0x44 in consecutive cycles -> same four words out, one per cycle from N+1, TLAST only on 0x44, TSTRB=0xF.
REQ-036 Backpressure/full: TREADY=0; push 0xA0..0xA5 -> ready drops after 4 accepts; TVALID=1 with TDATA stable at 0xA0. Release TREADY -> 0xA0..0xA3 drain in order, then 0xA4 and 0xA5 are accepted.
REQ-037 Full with simultaneous pop: 4 entries, TREADY=1, data_valid=1 -> no push that cycle; ready=1 next cycle; order is preserved.
REQ-038 Stop mid-stream: 3 words buffered, TREADY=0; drop start -> ready=0 immediately; raise TREADY -> all 3 words drain.
REQ-039 Reset mid-packet: 2 words buffered, assert reset 1 cycle -> TVALID=0 next cycle, and the old words never appear.
